// File: rtl/cfg_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_scheduler_pkg
// Description : Shared types, default constants and width helper for the
//               interrupter config-bus scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_scheduler_pkg;

  // Scheduler top-level states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_WAIT = 2'd1,
    LOCK      = 2'd2
  } state_t;

  // Default parameter values
  localparam int C_DEF_PAR_MAX_VAL   = 255;
  localparam int C_DEF_ADDR_MAX      = 4;
  localparam int C_DEF_ADDR_PW       = 2;
  localparam int C_DEF_RAMP_DIV      = 1000;
  localparam int C_DEF_RAMP_STEP     = 1;
  localparam int C_DEF_FAULT_CNT_MAX = 7;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cfg_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : cfg_scheduler_tick_gen
// Description : Free-running clock divider; tick is high for one cycle out of
//               every DIV cycles (DIV >= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_scheduler_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW     = $clog2(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIV-1 and wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + C_ONE;
  end

  assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cfg_scheduler
// Description : Sole master of the interrupter config bus. Arbitrates fault
//               kill writes, host command writes and a soft-start ramp of the
//               pulse-width register (priority kill > host > ramp).
//               Optional macro CFG_FAULT_DECAY_EN: fault count decays by one
//               every 256 ramp ticks while nonzero and not locked.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_scheduler
  import cfg_scheduler_pkg::*;
#(
  parameter int PAR_MAX_VAL   = C_DEF_PAR_MAX_VAL,
  parameter int ADDR_MAX      = C_DEF_ADDR_MAX,
  parameter int ADDR_PW       = C_DEF_ADDR_PW,
  parameter int RAMP_DIV      = C_DEF_RAMP_DIV,
  parameter int RAMP_STEP     = C_DEF_RAMP_STEP,
  parameter int FAULT_CNT_MAX = C_DEF_FAULT_CNT_MAX,
  localparam int DW = cfg_width(PAR_MAX_VAL),
  localparam int AW = cfg_width(ADDR_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] host_data,
  input  logic [AW-1:0] host_addr,
  input  logic          host_req,
  output logic          host_ack,
  input  logic          fault,
  output logic [DW-1:0] bus_data,
  output logic [AW-1:0] bus_addr,
  output logic          bus_en,
  output logic [DW-1:0] pw_cur,
  output logic          locked
);

  localparam int            FW         = cfg_width(FAULT_CNT_MAX);
  localparam logic [AW-1:0] C_ADDR_PW  = AW'(ADDR_PW);
  localparam logic [FW-1:0] C_FCNT_MAX = FW'(FAULT_CNT_MAX);
  localparam logic [FW-1:0] C_FCNT_ONE = FW'(1);
  localparam logic [DW:0]   C_STEP     = (DW + 1)'(RAMP_STEP);

  state_t        r_state;
  logic [DW-1:0] r_pw_target;
  logic [FW-1:0] r_fault_cnt;
  logic          r_ramp_pend;

  logic          w_tick;
  logic          w_host_pw;
  logic [FW-1:0] w_cnt_inc;
  logic [DW:0]   w_step_sum;
  logic [DW-1:0] w_step_val;

`ifdef CFG_FAULT_DECAY_EN
  logic [7:0]    r_decay_cnt;
`endif

  cfg_scheduler_tick_gen #(
    .DIV (RAMP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_host_pw  = (host_addr == C_ADDR_PW);
  assign w_cnt_inc  = (r_fault_cnt == C_FCNT_MAX) ? r_fault_cnt : r_fault_cnt + C_FCNT_ONE;
  // One bit wider so a step near PAR_MAX_VAL cannot wrap before the clamp
  assign w_step_sum = {1'b0, pw_cur} + C_STEP;
  assign w_step_val = (w_step_sum > {1'b0, r_pw_target}) ? r_pw_target : w_step_sum[DW-1:0];

  // Arbitration FSM: kill > host > ramp, at most one bus write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pw_target <= '0;
      r_fault_cnt <= '0;
      r_ramp_pend <= 1'b0;
      host_ack    <= 1'b0;
      bus_en      <= 1'b0;
      bus_data    <= '0;
      bus_addr    <= '0;
      pw_cur      <= '0;
      locked      <= 1'b0;
`ifdef CFG_FAULT_DECAY_EN
      r_decay_cnt <= '0;
`endif
    end else begin
      host_ack <= 1'b0;
      bus_en   <= 1'b0;

`ifdef CFG_FAULT_DECAY_EN
      // Later assignments (fault, lock clear) override this decrement
      if (w_tick) begin
        r_decay_cnt <= r_decay_cnt + 8'd1;
        if (r_decay_cnt == 8'hFF && r_fault_cnt != '0 && !locked)
          r_fault_cnt <= r_fault_cnt - C_FCNT_ONE;
      end
`endif

      if (fault) begin
        bus_en      <= 1'b1;
        bus_addr    <= C_ADDR_PW;
        bus_data    <= '0;
        pw_cur      <= '0;
        r_fault_cnt <= w_cnt_inc;
        r_ramp_pend <= 1'b0;
        if (w_cnt_inc == C_FCNT_MAX) begin
          locked <= 1'b1;
          // An open handshake finishes first and then lands in LOCK
          if (r_state != HOST_WAIT) r_state <= LOCK;
        end
      end else begin
        case (r_state)
          IDLE, LOCK: begin
            if (host_req) begin
              host_ack <= 1'b1;
              r_state  <= HOST_WAIT;
              if (!w_host_pw) begin
                bus_en   <= 1'b1;
                bus_addr <= host_addr;
                bus_data <= host_data;
              end else if (!locked) begin
                r_pw_target <= host_data;
              end else if (host_data == '0) begin
                locked      <= 1'b0;
                r_fault_cnt <= '0;
                r_pw_target <= '0;
              end
            end else if (r_state == IDLE) begin
              if (r_pw_target < pw_cur) begin
                // Decreases take effect at once, no ramp
                bus_en      <= 1'b1;
                bus_addr    <= C_ADDR_PW;
                bus_data    <= r_pw_target;
                pw_cur      <= r_pw_target;
                r_ramp_pend <= 1'b0;
              end else if (r_ramp_pend) begin
                r_ramp_pend <= 1'b0;
                if (pw_cur < r_pw_target) begin
                  bus_en   <= 1'b1;
                  bus_addr <= C_ADDR_PW;
                  bus_data <= w_step_val;
                  pw_cur   <= w_step_val;
                end
              end
            end
          end
          HOST_WAIT: begin
            if (!host_req) r_state <= locked ? LOCK : IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end

      // A tick arms the next step; placed last so it is not lost to a service
      if (w_tick && !fault && !locked && pw_cur < r_pw_target)
        r_ramp_pend <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_scheduler
// Description : Directed self-checking bench for cfg_scheduler
//               (RAMP_DIV=4, FAULT_CNT_MAX=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_scheduler;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] host_data = '0;
  logic [2:0] host_addr = '0;
  logic       host_req = 1'b0;
  logic       host_ack;
  logic       fault = 1'b0;
  logic [7:0] bus_data;
  logic [2:0] bus_addr;
  logic       bus_en;
  logic [7:0] pw_cur;
  logic       locked;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cfg_scheduler #(
    .PAR_MAX_VAL   (255),
    .ADDR_MAX      (4),
    .ADDR_PW       (2),
    .RAMP_DIV      (RD),
    .RAMP_STEP     (1),
    .FAULT_CNT_MAX (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_data (host_data),
    .host_addr (host_addr),
    .host_req  (host_req),
    .host_ack  (host_ack),
    .fault     (fault),
    .bus_data  (bus_data),
    .bus_addr  (bus_addr),
    .bus_en    (bus_en),
    .pw_cur    (pw_cur),
    .locked    (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_req = 1'b0; fault = 1'b0; host_addr = '0; host_data = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_bus(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (bus_en) seen = 1'b1;
    end
  endtask

  task automatic count_bus(input int n, output int writes);
    writes = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus_en) writes++;
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d, input int hold,
                            output int n_ack, output int n_bus,
                            output logic [2:0] ba, output logic [7:0] bd);
    n_ack = 0; n_bus = 0; ba = '0; bd = '0;
    host_addr = a; host_data = d; host_req = 1'b1;
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) host_req = 1'b0;
      step();
      if (host_ack) n_ack++;
      if (bus_en) begin n_bus++; ba = bus_addr; bd = bus_data; end
    end
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b1; host_req = 1'b0; fault = 1'b0;
    #3;
    total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", host_ack); end
    total++; if (bus_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", bus_en); end
    total++; if (bus_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus_data); end
    total++; if (bus_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus_addr); end
    total++; if (pw_cur !== 8'h00) begin bad++; $display("FAIL reset_pw got=%h exp=00", pw_cur); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    step(); step();
    rst = 1'b0;
    count_bus(10 * RD, w);
    total++; if (w !== 0) begin bad++; $display("FAIL idle_quiet writes=%0d exp=0", w); end
  endtask

  task automatic test_ramp();
    int na, nb, prev, w;
    logic [2:0] ba; logic [7:0] bd;
    bit seen;
    do_reset();
    host_write(3'd2, 8'd5, 1, na, nb, ba, bd);
    total++; if (na !== 1) begin bad++; $display("FAIL ramp_ack acks=%0d exp=1", na); end
    total++; if (nb !== 0) begin bad++; $display("FAIL ramp_pw_nobus writes=%0d exp=0", nb); end
    prev = 0;
    for (int v = 1; v <= 5; v++) begin
      wait_bus(3 * RD, seen);
      total++;
      if (!seen) begin bad++; $display("FAIL ramp_timeout step=%0d no bus_en", v); end
      else if (bus_addr !== 3'd2 || bus_data !== 8'(v) || pw_cur !== 8'(v)) begin
        bad++; $display("FAIL ramp_step%0d addr=%0d data=%0d pw=%0d exp addr=2 data=%0d", v, bus_addr, bus_data, pw_cur, v);
      end
      if (v >= 3) begin
        total++;
        if (cyc - prev !== RD) begin bad++; $display("FAIL ramp_spacing step=%0d got=%0d exp=%0d", v, cyc - prev, RD); end
      end
      prev = cyc;
    end
    count_bus(3 * RD, w);
    total++; if (w !== 0) begin bad++; $display("FAIL ramp_at_target writes=%0d exp=0", w); end
    host_write(3'd2, 8'd3, 1, na, nb, ba, bd);
    total++; if (na !== 1) begin bad++; $display("FAIL dec_ack acks=%0d exp=1", na); end
    wait_bus(4, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL dec_timeout no bus_en"); end
    else if (bus_addr !== 3'd2 || bus_data !== 8'd3 || pw_cur !== 8'd3) begin
      bad++; $display("FAIL dec_write addr=%0d data=%0d pw=%0d exp addr=2 data=3", bus_addr, bus_data, pw_cur);
    end
  endtask

  task automatic test_hold();
    int na, nb;
    logic [2:0] ba; logic [7:0] bd;
    do_reset();
    host_write(3'd1, 8'h40, 20, na, nb, ba, bd);
    total++; if (na !== 1) begin bad++; $display("FAIL hold_acks got=%0d exp=1", na); end
    total++; if (nb !== 1) begin bad++; $display("FAIL hold_writes got=%0d exp=1", nb); end
    total++; if (ba !== 3'd1) begin bad++; $display("FAIL hold_addr got=%0d exp=1", ba); end
    total++; if (bd !== 8'h40) begin bad++; $display("FAIL hold_data got=%h exp=40", bd); end
  endtask

  task automatic test_fault_collision();
    int na, nb;
    logic [2:0] ba; logic [7:0] bd;
    bit seen;
    do_reset();
    host_write(3'd2, 8'd5, 1, na, nb, ba, bd);
    wait_bus(3 * RD, seen);
    wait_bus(3 * RD, seen);
    total++;
    if (!seen || bus_data !== 8'd2) begin bad++; $display("FAIL coll_setup seen=%b data=%0d exp data=2", seen, bus_data); end
    // A step write lands one cycle after a tick; the next tick is RD-1 cycles on
    step(); step();
    fault = 1'b1; host_req = 1'b1; host_addr = 3'd1; host_data = 8'h22;
    step();
    fault = 1'b0;
    total++;
    if (bus_en !== 1'b1 || bus_addr !== 3'd2 || bus_data !== 8'd0) begin
      bad++; $display("FAIL coll_kill en=%b addr=%0d data=%0d exp en=1 addr=2 data=0", bus_en, bus_addr, bus_data);
    end
    total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL coll_ack_early got=%b exp=0", host_ack); end
    total++; if (pw_cur !== 8'd0) begin bad++; $display("FAIL coll_pw got=%0d exp=0", pw_cur); end
    step();
    host_req = 1'b0;
    total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL coll_ack_late got=%b exp=1", host_ack); end
    total++;
    if (bus_en !== 1'b1 || bus_addr !== 3'd1 || bus_data !== 8'h22) begin
      bad++; $display("FAIL coll_host_write en=%b addr=%0d data=%h exp en=1 addr=1 data=22", bus_en, bus_addr, bus_data);
    end
    wait_bus(3 * RD, seen);
    total++;
    if (!seen || bus_addr !== 3'd2 || bus_data !== 8'd1) begin
      bad++; $display("FAIL coll_ramp_restart seen=%b addr=%0d data=%0d exp addr=2 data=1", seen, bus_addr, bus_data);
    end
  endtask

  task automatic pulse_fault(input int k);
    fault = 1'b1;
    step();
    fault = 1'b0;
    total++;
    if (bus_en !== 1'b1 || bus_addr !== 3'd2 || bus_data !== 8'd0) begin
      bad++; $display("FAIL kill%0d en=%b addr=%0d data=%0d exp en=1 addr=2 data=0", k, bus_en, bus_addr, bus_data);
    end
    step(); step(); step();
  endtask

  task automatic test_lockout();
    int na, nb, w;
    logic [2:0] ba; logic [7:0] bd;
    do_reset();
    host_write(3'd2, 8'd5, 1, na, nb, ba, bd);
    step(); step(); step(); step(); step();
    pulse_fault(1);
    pulse_fault(2);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", locked); end
    pulse_fault(3);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_set got=%b exp=1", locked); end
    count_bus(5 * RD, w);
    total++; if (w !== 0 || pw_cur !== 8'd0) begin bad++; $display("FAIL lock_frozen writes=%0d pw=%0d exp 0/0", w, pw_cur); end
    host_write(3'd2, 8'd9, 1, na, nb, ba, bd);
    total++; if (na !== 1 || nb !== 0) begin bad++; $display("FAIL lock_pw9 acks=%0d writes=%0d exp 1/0", na, nb); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_kept got=%b exp=1", locked); end
    host_write(3'd1, 8'd7, 1, na, nb, ba, bd);
    total++;
    if (na !== 1 || nb !== 1 || ba !== 3'd1 || bd !== 8'd7) begin
      bad++; $display("FAIL lock_fwd acks=%0d writes=%0d addr=%0d data=%0d exp 1/1/1/7", na, nb, ba, bd);
    end
    host_write(3'd2, 8'd0, 1, na, nb, ba, bd);
    total++; if (na !== 1 || locked !== 1'b0) begin bad++; $display("FAIL lock_clear acks=%0d locked=%b exp 1/0", na, locked); end
    count_bus(3 * RD, w);
    total++; if (w !== 0) begin bad++; $display("FAIL clear_quiet writes=%0d exp=0", w); end
  endtask

  task automatic test_reset_mid();
    int na, nb, w;
    logic [2:0] ba; logic [7:0] bd;
    bit seen;
    do_reset();
    host_write(3'd2, 8'd5, 1, na, nb, ba, bd);
    wait_bus(3 * RD, seen);
    wait_bus(3 * RD, seen);
    #2 rst = 1'b1;
    #1;
    total++; if (pw_cur !== 8'd0 || bus_en !== 1'b0) begin bad++; $display("FAIL midrst pw=%0d en=%b exp 0/0", pw_cur, bus_en); end
    step();
    rst = 1'b0;
    count_bus(3 * RD, w);
    total++; if (w !== 0) begin bad++; $display("FAIL midrst_quiet writes=%0d exp=0", w); end
  endtask

  task automatic test_decay();
    logic exp_lock;
`ifdef CFG_FAULT_DECAY_EN
    exp_lock = 1'b0;
`else
    exp_lock = 1'b1;
`endif
    do_reset();
    pulse_fault(1);
    pulse_fault(2);
    for (int i = 0; i < 520 * RD; i++) step();
    pulse_fault(3);
    total++; if (locked !== exp_lock) begin bad++; $display("FAIL decay_lock got=%b exp=%b", locked, exp_lock); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hold();
    test_fault_collision();
    test_lockout();
    test_reset_mid();
    test_decay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
